// File: rtl/trace_log_buffer.sv
// -----------------------------------------------------------------------------
// trace_log_buffer
//
// Purpose:
//   Decouples the trace logger's log branch from the trace sink. Every accepted
//   log beat is stamped with a free-running cycle timestamp and stored as a
//   {timestamp, data} record in a DEPTH-entry FIFO. Records leave on a
//   valid/ready stream with show-ahead data, so a sink stall never reaches
//   back through the logger's fork onto the monitored AXI channel (in drop
//   mode) or only back-pressures the log branch (default mode).
//
// Build option:
//   TRACE_LOG_DROP_EN  defined   -> log_ready_o is high whenever out of reset;
//                                   beats arriving while full are discarded
//                                   and counted in a saturating drop counter.
//                      undefined -> full FIFO back-pressures the logger;
//                                   drop_cnt_o is constant 0.
//
// Ports:
//   clk          in   1                     clock
//   rst_n        in   1                     asynchronous active-low reset
//   trace_en_i   in   1                     1 = record beats, 0 = sink and discard
//   log_valid_i  in   1                     log beat valid
//   log_ready_o  out  1                     log beat ready
//   log_data_i   in   DATA_WIDTH            log beat payload
//   rec_valid_o  out  1                     record valid to the sink
//   rec_ready_i  in   1                     record ready from the sink
//   rec_data_o   out  TS_WIDTH+DATA_WIDTH   record {ts, data}, head of FIFO
//   level_o      out  $clog2(DEPTH)+1       FIFO occupancy 0..DEPTH
//   drop_cnt_o   out  DROP_CNT_WIDTH        beats dropped while full
// -----------------------------------------------------------------------------
module trace_log_buffer #(
    parameter int DATA_WIDTH     = 64,
    parameter int TS_WIDTH       = 32,
    parameter int DEPTH          = 16,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           trace_en_i,
    input  logic                           log_valid_i,
    output logic                           log_ready_o,
    input  logic [DATA_WIDTH-1:0]          log_data_i,
    output logic                           rec_valid_o,
    input  logic                           rec_ready_i,
    output logic [TS_WIDTH+DATA_WIDTH-1:0] rec_data_o,
    output logic [$clog2(DEPTH):0]         level_o,
    output logic [DROP_CNT_WIDTH-1:0]      drop_cnt_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int REC_W = TS_WIDTH + DATA_WIDTH;

    localparam logic [PTR_W-1:0]    PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [TS_WIDTH-1:0] TS_ONE  = {{(TS_WIDTH-1){1'b0}}, 1'b1};

    // Pointer advance; the extra MSB toggles on every wrap of the index bits.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_ONE;
    endfunction

    // Control state
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [PTR_W-1:0]    wp_q, wp_d;
    logic [PTR_W-1:0]    rp_q, rp_d;

    // Record storage: data only, intentionally not reset
    logic [REC_W-1:0]    mem_q [DEPTH];

    logic empty;
    logic full;
    logic beat;
    logic push;
    logic pop;

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[IDX_W-1:0] == rp_q[IDX_W-1:0]) &&
                   (wp_q[IDX_W]     != rp_q[IDX_W]);

`ifdef TRACE_LOG_DROP_EN
    // Never stall the logger branch once out of reset.
    assign log_ready_o = rst_n;
`else
    // Discard mode is always ready; recording mode stalls only when full.
    // A pop in the same cycle does not open the gate (no pass-through).
    assign log_ready_o = rst_n & (~trace_en_i | ~full);
`endif

    assign beat = log_valid_i & log_ready_o & trace_en_i;
    // The full qualifier only matters in drop mode; it is redundant otherwise.
    assign push = beat & ~full;
    assign pop  = ~empty & rec_ready_i;

    assign rec_valid_o = ~empty;
    assign rec_data_o  = mem_q[rp_q[IDX_W-1:0]];
    assign level_o     = wp_q - rp_q;

    always_comb begin
        ts_d = ts_q + TS_ONE;
        wp_d = push ? ptr_inc(wp_q) : wp_q;
        rp_d = pop  ? ptr_inc(rp_q) : rp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            ts_q <= ts_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Record write: timestamp is the counter value in the handshake cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q[IDX_W-1:0]] <= {ts_q, log_data_i};
        end
    end

`ifdef TRACE_LOG_DROP_EN
    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
        input logic [DROP_CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic                      drop;

    // An enabled beat that finds the FIFO full is lost even if a pop
    // happens in the same cycle.
    assign drop = beat & full;

    always_comb begin
        drop_d = drop ? sat_inc(drop_q) : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt_o = drop_q;
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_trace_log_buffer.sv
module tb_trace_log_buffer;

    localparam int DW    = 64;
    localparam int TW    = 32;
    localparam int DEPTH = 16;
    localparam int DCW   = 16;
    localparam int RW    = TW + DW;

    logic           clk;
    logic           rst_n;
    logic           trace_en;
    logic           log_valid;
    logic           log_ready;
    logic [DW-1:0]  log_data;
    logic           rec_valid;
    logic           rec_ready;
    logic [RW-1:0]  rec_data;
    logic [4:0]     level;
    logic [DCW-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    trace_log_buffer #(
        .DATA_WIDTH(DW), .TS_WIDTH(TW), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trace_en_i(trace_en),
        .log_valid_i(log_valid), .log_ready_o(log_ready), .log_data_i(log_data),
        .rec_valid_o(rec_valid), .rec_ready_i(rec_ready), .rec_data_o(rec_data),
        .level_o(level), .drop_cnt_o(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model / scoreboard: records pushed at the modelled handshake,
    // popped at the modelled pop; tasks compare the DUT head against sb[0].
    logic [RW-1:0] sb[$];
    int            exp_lvl;
    int            exp_drop;
    logic [TW-1:0] ts_m;
    bit            m_full, m_push, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            exp_lvl  = 0;
            exp_drop = 0;
            ts_m     = '0;
        end else begin
            m_full = (exp_lvl == DEPTH);
            m_pop  = (exp_lvl != 0) && rec_ready;
            m_push = log_valid && trace_en && !m_full;
`ifdef TRACE_LOG_DROP_EN
            if (log_valid && trace_en && m_full && exp_drop < 65535) exp_drop++;
`endif
            if (m_pop) begin
                void'(sb.pop_front());
                exp_lvl--;
            end
            if (m_push) begin
                sb.push_back({ts_m, log_data});
                exp_lvl++;
            end
            ts_m = ts_m + 1;
        end
    end

    function automatic bit exp_ready();
`ifdef TRACE_LOG_DROP_EN
        return rst_n;
`else
        return rst_n && (!trace_en || exp_lvl < DEPTH);
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; log_valid = 0; rec_ready = 0; trace_en = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; trace_en = 1; log_valid = 0; rec_ready = 0; log_data = '0;
        @(negedge clk);
        checks++; if (log_ready !== 1'b0) begin errors++; $display("FAIL reset_log_ready got %0b want 0", log_ready); end
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_rec_valid got %0b want 0", rec_valid); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        checks++; if (log_ready !== 1'b1) begin errors++; $display("FAIL post_reset_log_ready got %0b want 1", log_ready); end
        checks++; if (rec_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL post_reset_empty got v=%0b l=%0d want v=0 l=0", rec_valid, level); end
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        d = 64'h1122334455667788;
        do_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        log_valid = 1; log_data = d; rec_ready = 1;
        @(negedge clk);
        log_valid = 0;
        checks++; if (rec_valid !== 1'b1 || level !== 5'd1) begin errors++; $display("FAIL single_visible got v=%0b l=%0d want v=1 l=1", rec_valid, level); end
        checks++; if (rec_data !== {32'd5, d}) begin errors++; $display("FAIL single_data got %h want %h", rec_data, {32'd5, d}); end
        checks++; if (sb.size() != 1 || rec_data !== sb[0]) begin errors++; $display("FAIL single_sb got %h want %h", rec_data, (sb.size() != 0) ? sb[0] : '0); end
        @(negedge clk);
        checks++; if (rec_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL single_drained got v=%0b l=%0d want v=0 l=0", rec_valid, level); end
        rec_ready = 0;
    endtask

    task automatic test_full();
        logic [DW-1:0] idx;
        bit acc;
        int acc_c;
        rec_ready = 0;
        for (int i = 0; i < 16; i++) begin
            log_valid = 1; log_data = DW'(i);
            @(negedge clk);
        end
        log_data = 64'd16;
        #1;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level got %0d want 16", level); end
        checks++; if (log_ready !== 1'b0) begin errors++; $display("FAIL full_backpressure got %0b want 0", log_ready); end
        repeat (2) @(negedge clk);
        checks++; if (log_ready !== 1'b0 || level !== 5'd16) begin errors++; $display("FAIL full_hold got r=%0b l=%0d want r=0 l=16", log_ready, level); end
        rec_ready = 1;
        #1;
        checks++; if (log_ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru got %0b want 0", log_ready); end
        idx = '0; acc_c = -1;
        for (int c = 0; c < 60 && (exp_lvl != 0 || log_valid); c++) begin
            if (log_valid) begin
                checks++; if (log_ready !== exp_ready()) begin errors++; $display("FAIL full_drain_ready c=%0d got %0b want %0b", c, log_ready, exp_ready()); end
            end
            if (exp_lvl != 0) begin
                checks++; if (rec_data !== sb[0] || rec_data[DW-1:0] !== idx) begin errors++; $display("FAIL full_drain_data got %h want %h idx %0d", rec_data, sb[0], idx); end
                idx++;
            end
            acc = log_valid && exp_ready();
            if (acc) acc_c = c;
            @(negedge clk);
            if (acc) log_valid = 0;
        end
        checks++; if (idx !== 64'd17 || exp_lvl != 0) begin errors++; $display("FAIL full_drain_count got %0d want 17", idx); end
        checks++; if (acc_c != 1) begin errors++; $display("FAIL full_17th_accept got cycle %0d want 1", acc_c); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL full_final_level got %0d want 0", level); end
        rec_ready = 0;
    endtask

    task automatic test_stream();
        rec_ready = 1;
        for (int i = 0; i < 40; i++) begin
            log_valid = 1; log_data = DW'(1000 + i);
            @(negedge clk);
            checks++; if (level !== 5'd1 || rec_valid !== 1'b1) begin errors++; $display("FAIL stream_level i=%0d got l=%0d v=%0b want l=1 v=1", i, level, rec_valid); end
            checks++; if (sb.size() == 0 || rec_data !== sb[0] || rec_data[DW-1:0] !== DW'(1000 + i)) begin errors++; $display("FAIL stream_data i=%0d got %h want low %0d", i, rec_data, 1000 + i); end
        end
        log_valid = 0;
        @(negedge clk);
        checks++; if (level !== 5'd0 || rec_valid !== 1'b0) begin errors++; $display("FAIL stream_end got l=%0d v=%0b want 0 0", level, rec_valid); end
        rec_ready = 0;
    endtask

    task automatic test_disabled();
        trace_en = 0; rec_ready = 0;
        for (int i = 0; i < 8; i++) begin
            log_valid = 1; log_data = DW'(200 + i);
            #1;
            checks++; if (log_ready !== 1'b1) begin errors++; $display("FAIL disabled_ready i=%0d got %0b want 1", i, log_ready); end
            @(negedge clk);
            checks++; if (level !== 5'd0 || rec_valid !== 1'b0) begin errors++; $display("FAIL disabled_empty i=%0d got l=%0d v=%0b want 0 0", i, level, rec_valid); end
        end
        log_valid = 0; trace_en = 1;
    endtask

    task automatic test_hold();
        logic [RW-1:0] held;
        log_valid = 1; log_data = 64'hDEAD_BEEF_0000_0001; rec_ready = 0;
        @(negedge clk);
        held = rec_data;
        trace_en = 0;
        for (int i = 0; i < 3; i++) begin
            log_data = DW'(300 + i);
            @(negedge clk);
            checks++; if (rec_valid !== 1'b1 || level !== 5'd1 || rec_data !== held || rec_data !== sb[0]) begin errors++; $display("FAIL hold_stable i=%0d got v=%0b l=%0d d=%h want v=1 l=1 d=%h", i, rec_valid, level, rec_data, sb[0]); end
        end
        log_valid = 0; rec_ready = 1;
        @(negedge clk);
        checks++; if (rec_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL hold_pop got v=%0b l=%0d want 0 0", rec_valid, level); end
        rec_ready = 0; trace_en = 1;
    endtask

    task automatic test_drop();
        logic [DW-1:0] idx;
        rec_ready = 0;
`ifdef TRACE_LOG_DROP_EN
        for (int i = 0; i < 19; i++) begin
            log_valid = 1; log_data = DW'(i);
            #1;
            checks++; if (log_ready !== 1'b1) begin errors++; $display("FAIL drop_ready i=%0d got %0b want 1", i, log_ready); end
            @(negedge clk);
        end
        log_valid = 0;
        checks++; if (drop_cnt !== DCW'(exp_drop) || drop_cnt !== 16'd3) begin errors++; $display("FAIL drop_count got %0d want 3", drop_cnt); end
`else
        for (int i = 0; i < 18; i++) begin
            log_valid = 1; log_data = DW'(i);
            @(negedge clk);
        end
        log_valid = 0;
        checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL drop_tied got %0d want 0", drop_cnt); end
`endif
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL drop_level got %0d want 16", level); end
        rec_ready = 1; idx = '0;
        for (int c = 0; c < 40 && exp_lvl != 0; c++) begin
            checks++; if (rec_data !== sb[0] || rec_data[DW-1:0] !== idx) begin errors++; $display("FAIL drop_drain got %h want low %0d", rec_data, idx); end
            idx++;
            @(negedge clk);
        end
        checks++; if (idx !== 64'd16 || level !== 5'd0) begin errors++; $display("FAIL drop_drain_count got %0d l=%0d want 16 l=0", idx, level); end
        rec_ready = 0;
    endtask

    task automatic test_reset_mid();
        rec_ready = 0;
        for (int i = 0; i < 5; i++) begin
            log_valid = 1; log_data = DW'(500 + i);
            @(negedge clk);
        end
        log_valid = 0; rec_ready = 1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (rec_data !== sb[0] || rec_data[DW-1:0] !== DW'(500 + i)) begin errors++; $display("FAIL mid_drain i=%0d got %h want low %0d", i, rec_data, 500 + i); end
            @(negedge clk);
        end
        rst_n = 0; rec_ready = 0;
        #1;
        checks++; if (rec_valid !== 1'b0 || level !== 5'd0 || log_ready !== 1'b0) begin errors++; $display("FAIL mid_reset got v=%0b l=%0d r=%0b want 0 0 0", rec_valid, level, log_ready); end
        @(negedge clk);
        rst_n = 1; log_valid = 1; log_data = 64'hAA;
        @(negedge clk);
        log_data = 64'hBB;
        @(negedge clk);
        log_valid = 0;
        checks++; if (level !== 5'd2) begin errors++; $display("FAIL mid_level got %0d want 2", level); end
        checks++; if (rec_data !== {32'd0, 64'hAA} || rec_data !== sb[0]) begin errors++; $display("FAIL mid_ts0 got %h want %h", rec_data, {32'd0, 64'hAA}); end
        rec_ready = 1;
        @(negedge clk);
        checks++; if (rec_data !== {32'd1, 64'hBB}) begin errors++; $display("FAIL mid_ts1 got %h want %h", rec_data, {32'd1, 64'hBB}); end
        @(negedge clk);
        checks++; if (level !== 5'd0 || rec_valid !== 1'b0) begin errors++; $display("FAIL mid_end got l=%0d v=%0b want 0 0", level, rec_valid); end
        rec_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_stream();
        test_disabled();
        test_hold();
        test_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
